uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 9600-baud, 8N1 UART byte transmitter among REQ_NUM requesters.
- Picks one pending requester, latches its byte and acknowledges it.
- Pulses the transmitter's start input, then waits for the transmitter's done pulse (or a timeout) before serving the next requester.
- Sits between user logic (switch sampler, status reporters) and the byte transmitter that drives the board TX pin.

Parameters:
REQ_NUM, 4, number of requesters (2..8); owner index width OW = $clog2(REQ_NUM)
TX_TIMEOUT_MAX, 52079, maximum WAIT cycles without i_tx_done (10 bits x 5208 clocks at 50 MHz, minus 1)

Ports:
i_sysclk  input  1  system clock, 50 MHz
i_rst_n  input  1  asynchronous active-low reset
i_req  input  REQ_NUM  bit r high: requester r has a byte pending; held until o_ack[r]
i_data  input  8*REQ_NUM  requester r byte at [8r+7:8r]; stable while i_req[r] high
o_ack  output  REQ_NUM  one-cycle pulse: requester r byte accepted
o_tx_start  output  1  one-cycle start pulse to byte transmitter
o_tx_data  output  8  latched byte; held stable from start until return to IDLE
i_tx_done  input  1  one-cycle pulse from transmitter after stop bit
o_busy  output  1  high while a byte is in flight (WAIT state)
o_owner  output  OW  index of the last granted requester
o_err  output  1  one-cycle pulse on transmitter timeout

Behaviour:
- Clock and reset: one clock, i_sysclk. Reset is asynchronous, active-low, on i_rst_n.
- Reset values: state=IDLE; o_ack=0, o_tx_start=0, o_tx_data=8'h00, o_busy=0, o_owner=0, o_err=0; rr pointer=0; timeout counter=0.
- States: IDLE, WAIT.
- IDLE, i_req==0: stay in IDLE; all pulses low.
- IDLE, i_req!=0: grant the first set bit scanning ptr, ptr+1, ..., wrapping modulo REQ_NUM. Let g be the granted index. Registered outputs on the next clock:
  - o_ack[g]=1 and o_tx_start=1, both for one cycle
  - o_tx_data=i_data[8g+7:8g], o_owner=g, o_busy=1
  - state goes to WAIT; timeout counter cleared
- Latency: req sampled at edge k -> ack/start high during cycle k+1.
- WAIT: the counter increments every cycle.
  - i_tx_done=1: go to IDLE; o_busy=0; ptr=(owner+1) mod REQ_NUM.
  - Counter==TX_TIMEOUT_MAX with no done: go to IDLE; o_busy=0; o_err pulses for one cycle; ptr advances the same way.
  - Done and timeout in the same cycle: treat as done; o_err stays 0.
- Arbitration is ignored while in WAIT. Between bytes there is at least one IDLE cycle, so the transmitter always sees start at least 1 cycle after done.
- After ack, the requester drops i_req or presents its next byte and keeps i_req high. It rejoins round-robin behind the others, so fairness holds: no requester is served twice while another is pending.
- If a requester drops i_req before its ack, nothing is sent for it. A pulse that falls entirely within WAIT is lost, by design.
- i_tx_done while in IDLE: ignored, no state change.
- o_tx_data stays unchanged after return to IDLE until the next grant.
- Reset mid-WAIT: all outputs return to reset values immediately (asynchronous). Any byte in flight is abandoned; the transmitter is reset by the same i_rst_n.
- The one-hot grant and ptr arithmetic wrap modulo REQ_NUM. For non-power-of-2 REQ_NUM, index REQ_NUM-1 wraps to 0.

Test Plan:
1. Single request: i_req=4'b0100, i_data[23:16]=8'hA5; done pulsed 20 cycles after start -> one cycle after sampling: o_ack=4'b0100, o_tx_start=1, o_tx_data=8'hA5, o_owner=2, o_busy=1. o_busy=0 the cycle after done.
2. Round-robin: all four requesters held high with bytes 8'h10/8'h11/8'h12/8'h13; done returned each time -> grant order 0,1,2,3,0 and o_tx_data sequence 10,11,12,13,10. Every start occurs ≥1 cycle after the previous done.
3. Fairness after wrap: ptr=3 (after serving 2), i_req=4'b0101 -> requester 0 is granted before requester 2.
4. Timeout: one request, i_tx_done never pulsed -> o_err pulses exactly TX_TIMEOUT_MAX+1 cycles after start; busy drops; the next request is granted normally.
5. Simultaneous events: done pulsed on the same cycle as counter==TX_TIMEOUT_MAX -> o_err=0 and normal return to IDLE. Spurious done in IDLE -> no outputs change.
6. Reset mid-WAIT: assert i_rst_n=0 for 3 cycles during a transfer -> o_busy, o_ack and o_tx_start are 0 asynchronously, o_owner=0. After release, with i_req=4'b1000, requester 3 is granted first, with ptr=0 scanning.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter.
// Grants one requester, pulses start, waits for done or a timeout.
module uart_tx_arbiter #(
  parameter  int REQ_NUM        = 4,
  parameter  int TX_TIMEOUT_MAX = 52079,
  localparam int OW             = $clog2(REQ_NUM),
  localparam int CW             = $clog2(TX_TIMEOUT_MAX + 1)
) (
  input  logic                 i_sysclk,
  input  logic                 i_rst_n,
  input  logic [REQ_NUM-1:0]   i_req,
  input  logic [8*REQ_NUM-1:0] i_data,
  output logic [REQ_NUM-1:0]   o_ack,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic [OW-1:0]        o_owner,
  output logic                 o_err
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t             r_state;
  state_t             w_state;
  logic [OW-1:0]      r_ptr;
  logic [OW-1:0]      w_ptr;
  logic [OW-1:0]      r_owner;
  logic [OW-1:0]      w_owner;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt;
  logic [REQ_NUM-1:0] r_ack;
  logic [REQ_NUM-1:0] w_ack;
  logic [7:0]         r_data;
  logic [7:0]         w_data;
  logic               r_start;
  logic               w_start;
  logic               r_busy;
  logic               w_busy;
  logic               r_err;
  logic               w_err;

  logic               w_gnt_vld;
  logic [OW-1:0]      w_gnt_idx;
  logic [OW-1:0]      w_owner_inc;

  // pick the first pending requester at or after the rr pointer
  always_comb begin : p_gnt
    int k;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    k         = 0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      k = int'(r_ptr) + i;
      if (k >= REQ_NUM) k = k - REQ_NUM;
      if (i_req[k]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = OW'(k);
      end
    end
  end

  // pointer after the current owner, wrapping for any REQ_NUM
  always_comb begin
    w_owner_inc = (r_owner == OW'(REQ_NUM - 1)) ?
                  '0 : r_owner + OW'(1);
  end

  // next-state and registered-output values
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_owner = r_owner;
    w_cnt   = r_cnt;
    w_ack   = '0;
    w_data  = r_data;
    w_start = 1'b0;
    w_busy  = r_busy;
    w_err   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_state = S_WAIT;
          w_ack   = REQ_NUM'(1) << w_gnt_idx;
          w_start = 1'b1;
          w_data  = i_data[8*w_gnt_idx +: 8];
          w_owner = w_gnt_idx;
          w_busy  = 1'b1;
          w_cnt   = '0;
        end
      end
      S_WAIT: begin
        if (i_tx_done) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_ptr   = w_owner_inc;
        end else if (r_cnt == CW'(TX_TIMEOUT_MAX)) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_err   = 1'b1;
          w_ptr   = w_owner_inc;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_data  <= 8'h00;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_owner <= w_owner;
      r_cnt   <= w_cnt;
      r_ack   <= w_ack;
      r_data  <= w_data;
      r_start <= w_start;
      r_busy  <= w_busy;
      r_err   <= w_err;
    end
  end

  assign o_ack      = r_ack;
  assign o_tx_start = r_start;
  assign o_tx_data  = r_data;
  assign o_busy     = r_busy;
  assign o_owner    = r_owner;
  assign o_err      = r_err;

endmodule
